// File: rtl/adder_driver_if.sv
// Operand/result bundle between adder_driver and a 4-bit adder under test.
// The driver holds the master end; the adder (or its model) holds the slave end.
interface adder_driver_if;
  logic [3:0] a;
  logic [3:0] b;
  logic       valid;
  logic [6:0] c;

  modport master (output a, output b, output valid, input c);
  modport slave  (input a, input b, input valid, output c);
endinterface

// File: rtl/adder_driver.sv
// Self-test driver for the 4-bit adder family: issues LFSR operand pairs, checks c = a+b.
// Define ADDER_DRIVER_CORNER_EN to run 0+0 and 15+15 as the first two ops of each run.
module adder_driver #(
  parameter int         NUM_OPS = 16,
  parameter int         GAP     = 0,
  parameter logic [7:0] SEED    = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  adder_driver_if.master        bus,
  output logic                  busy,
  output logic                  done,
  output logic                  mismatch,
  output logic [7:0]            op_cnt,
  output logic [7:0]            err_cnt
);

`ifdef ADDER_DRIVER_CORNER_EN
  localparam bit CORNER = 1'b1;
`else
  localparam bit CORNER = 1'b0;
`endif

  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [7:0] NUM_OPS_C = 8'(NUM_OPS);
  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_CHECK, S_GAP, S_DONE} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  lfsr_reg, lfsr_next;
  logic [3:0]  a_reg, a_next;
  logic [3:0]  b_reg, b_next;
  logic [6:0]  exp_reg, exp_next;
  logic [7:0]  op_cnt_reg, op_cnt_next;
  logic [7:0]  err_cnt_reg, err_cnt_next;
  logic        mismatch_reg, mismatch_next;
  logic [3:0]  gap_cnt_reg, gap_cnt_next;
  logic        load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      lfsr_reg     <= SEED_EFF;
      a_reg        <= 4'd0;
      b_reg        <= 4'd0;
      exp_reg      <= 7'd0;
      op_cnt_reg   <= 8'd0;
      err_cnt_reg  <= 8'd0;
      mismatch_reg <= 1'b0;
      gap_cnt_reg  <= 4'd0;
    end else begin
      state_reg    <= state_next;
      lfsr_reg     <= lfsr_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      exp_reg      <= exp_next;
      op_cnt_reg   <= op_cnt_next;
      err_cnt_reg  <= err_cnt_next;
      mismatch_reg <= mismatch_next;
      gap_cnt_reg  <= gap_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    lfsr_next     = lfsr_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    exp_next      = exp_reg;
    op_cnt_next   = op_cnt_reg;
    err_cnt_next  = err_cnt_reg;
    mismatch_next = 1'b0;
    gap_cnt_next  = gap_cnt_reg;
    load          = 1'b0;

    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next   = S_ISSUE;
          lfsr_next    = SEED_EFF;
          op_cnt_next  = 8'd0;
          err_cnt_next = 8'd0;
          load         = 1'b1;
        end
      end
      S_ISSUE: state_next = S_CHECK;
      S_CHECK: begin
        op_cnt_next = op_cnt_reg + 8'd1;
        if (bus.c != exp_reg) begin
          mismatch_next = 1'b1;
          if (err_cnt_reg != 8'hFF)
            err_cnt_next = err_cnt_reg + 8'd1;
        end
        // Corner ops use fixed operands, so they must not consume LFSR states.
        if (!(CORNER && (op_cnt_reg < 8'd2)))
          lfsr_next = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[6] ^ lfsr_reg[5] ^ lfsr_reg[3]};
        if (op_cnt_next == NUM_OPS_C) begin
          state_next = S_DONE;
        end else if (GAP > 0) begin
          state_next   = S_GAP;
          gap_cnt_next = 4'd0;
        end else begin
          state_next = S_ISSUE;
          load       = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = S_ISSUE;
          load       = 1'b1;
        end else begin
          gap_cnt_next = gap_cnt_reg + 4'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Operands are registered on entry to ISSUE so they are stable for the whole valid cycle.
    if (load) begin
      if (CORNER && (op_cnt_next == 8'd0)) begin
        a_next = 4'h0;
        b_next = 4'h0;
      end else if (CORNER && (op_cnt_next == 8'd1)) begin
        a_next = 4'hF;
        b_next = 4'hF;
      end else begin
        a_next = lfsr_next[7:4];
        b_next = lfsr_next[3:0];
      end
      exp_next = {3'b000, a_next} + {3'b000, b_next};
    end
  end

  assign bus.a     = a_reg;
  assign bus.b     = b_reg;
  assign bus.valid = (state_reg == S_ISSUE);
  assign busy      = (state_reg == S_ISSUE) || (state_reg == S_CHECK) || (state_reg == S_GAP);
  assign done      = (state_reg == S_DONE);
  assign mismatch  = mismatch_reg;
  assign op_cnt    = op_cnt_reg;
  assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_adder_driver.sv
// Directed bench for adder_driver: three instances (default, GAP=3/NUM_OPS=2, NUM_OPS=3)
// each paired with a one-cycle-latency adder model.
module tb_adder_driver;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic force0 = 1'b0;

  logic       busy0, done0, mis0;
  logic [7:0] op0, err0;
  logic       busy1, done1, mis1;
  logic [7:0] op1, err1;
  logic       busy2, done2, mis2;
  logic [7:0] op2, err2;

  int vectors = 0;
  int miscompares = 0;

  adder_driver_if bus0();
  adder_driver_if bus1();
  adder_driver_if bus2();

  adder_driver dut0 (
    .clk(clk), .reset(reset), .start(start0), .bus(bus0),
    .busy(busy0), .done(done0), .mismatch(mis0), .op_cnt(op0), .err_cnt(err0)
  );
  adder_driver #(.NUM_OPS(2), .GAP(3)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .bus(bus1),
    .busy(busy1), .done(done1), .mismatch(mis1), .op_cnt(op1), .err_cnt(err1)
  );
  adder_driver #(.NUM_OPS(3)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .bus(bus2),
    .busy(busy2), .done(done2), .mismatch(mis2), .op_cnt(op2), .err_cnt(err2)
  );

  always #5 clk = ~clk;

  // Adder models: result registered one cycle after valid.
  always @(posedge clk) if (bus0.valid) bus0.c <= force0 ? 7'd0 : {3'b000, bus0.a} + {3'b000, bus0.b};
  always @(posedge clk) if (bus1.valid) bus1.c <= {3'b000, bus1.a} + {3'b000, bus1.b};
  always @(posedge clk) if (bus2.valid) bus2.c <= {3'b000, bus2.a} + {3'b000, bus2.b};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  initial begin
    int cyc;
    int nvalid;
    int nmis;
    int vcyc[4];
    logic [3:0] ea[3];
    logic [3:0] eb[3];
    logic [3:0] ga[3];
    logic [3:0] gb[3];

`ifdef ADDER_DRIVER_CORNER_EN
    ea[0] = 4'h0; eb[0] = 4'h0;
    ea[1] = 4'hF; eb[1] = 4'hF;
    ea[2] = 4'hA; eb[2] = 4'h5;
`else
    ea[0] = 4'hA; eb[0] = 4'h5;
    ea[1] = 4'h4; eb[1] = 4'hA;
    ea[2] = 4'h9; eb[2] = 4'h4;
`endif

    // Reset state
    tick();
    chk("rst_a", 32'(bus0.a), 32'h0);
    chk("rst_b", 32'(bus0.b), 32'h0);
    chk("rst_valid", 32'(bus0.valid), 32'h0);
    chk("rst_busy", 32'(busy0), 32'h0);
    chk("rst_done", 32'(done0), 32'h0);
    chk("rst_mismatch", 32'(mis0), 32'h0);
    chk("rst_op_cnt", 32'(op0), 32'h0);
    chk("rst_err_cnt", 32'(err0), 32'h0);
    reset = 1'b0;
    tick();

`ifndef ADDER_DRIVER_CORNER_EN
    // Run 1: correct adder, plus a start pulse while busy that must be ignored
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    cyc = 1;
    chk("r1_op0_valid", 32'(bus0.valid), 32'h1);
    chk("r1_op0_a", 32'(bus0.a), 32'hA);
    chk("r1_op0_b", 32'(bus0.b), 32'h5);
    chk("r1_busy", 32'(busy0), 32'h1);
    nvalid = 0;
    nmis = 0;
    while (!done0 && cyc < 100) begin
      if (bus0.valid) nvalid++;
      if (mis0) nmis++;
      if (cyc == 2) chk("r1_check_valid", 32'(bus0.valid), 32'h0);
      if (cyc == 2) chk("r1_check_a_hold", 32'(bus0.a), 32'hA);
      if (cyc == 3) chk("r1_op1_a", 32'(bus0.a), 32'h4);
      if (cyc == 3) chk("r1_op1_b", 32'(bus0.b), 32'hA);
      if (cyc == 3) chk("r1_op_cnt_after1", 32'(op0), 32'h1);
      start0 = (cyc == 10);
      tick();
      cyc++;
    end
    start0 = 1'b0;
    if (mis0) nmis++;
    $display("run1: done after %0d cycles, op_cnt=%0d err_cnt=%0d", cyc, op0, err0);
    chk("r1_done_cycle", 32'(cyc), 32'd33);
    chk("r1_valid_pulses", 32'(nvalid), 32'd16);
    chk("r1_mismatches", 32'(nmis), 32'd0);
    chk("r1_op_cnt", 32'(op0), 32'd16);
    chk("r1_err_cnt", 32'(err0), 32'd0);
    chk("r1_busy_end", 32'(busy0), 32'h0);
    tick();
    chk("r1_done_hold", 32'(done0), 32'h1);

    // Run 2: restart from DONE with the adder stuck at zero
    force0 = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    cyc = 1;
    chk("r2_op_cnt_clr", 32'(op0), 32'h0);
    chk("r2_done_clr", 32'(done0), 32'h0);
    chk("r2_op0_a", 32'(bus0.a), 32'hA);
    chk("r2_op0_b", 32'(bus0.b), 32'h5);
    nmis = 0;
    while (!done0 && cyc < 100) begin
      if (mis0) nmis++;
      if (cyc == 3) chk("r2_first_mismatch", 32'(mis0), 32'h1);
      if (cyc == 3) chk("r2_op1_a", 32'(bus0.a), 32'h4);
      tick();
      cyc++;
    end
    if (mis0) nmis++;
    $display("run2: done after %0d cycles, mismatches=%0d err_cnt=%0d", cyc, nmis, err0);
    chk("r2_done_cycle", 32'(cyc), 32'd33);
    chk("r2_mismatches", 32'(nmis), 32'd16);
    chk("r2_err_cnt", 32'(err0), 32'd16);
    force0 = 1'b0;

    // Run 3: reset during CHECK of the fifth op, then restart from the seed
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("r3_in_check", 32'(bus0.valid), 32'h0);
    chk("r3_op_cnt_mid", 32'(op0), 32'h4);
    #2 reset = 1'b1;
    #1;
    $display("run3: reset mid-run, busy=%0d op_cnt=%0d a=%0h", busy0, op0, bus0.a);
    chk("r3_rst_a", 32'(bus0.a), 32'h0);
    chk("r3_rst_b", 32'(bus0.b), 32'h0);
    chk("r3_rst_busy", 32'(busy0), 32'h0);
    chk("r3_rst_done", 32'(done0), 32'h0);
    chk("r3_rst_op_cnt", 32'(op0), 32'h0);
    chk("r3_rst_err_cnt", 32'(err0), 32'h0);
    chk("r3_rst_mismatch", 32'(mis0), 32'h0);
    reset = 1'b0;
    tick();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("r3_restart_a", 32'(bus0.a), 32'hA);
    chk("r3_restart_b", 32'(bus0.b), 32'h5);
    chk("r3_restart_valid", 32'(bus0.valid), 32'h1);

    // GAP=3, NUM_OPS=2: valid pulses 5 cycles apart, done at cycle 8
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    cyc = 1;
    nvalid = 0;
    while (!done1 && cyc < 40) begin
      if (bus1.valid && nvalid < 4) begin
        vcyc[nvalid] = cyc;
        nvalid++;
      end
      tick();
      cyc++;
    end
    $display("gap run: valid at %0d and %0d, done at %0d", vcyc[0], vcyc[1], cyc);
    chk("gap_valid_count", 32'(nvalid), 32'd2);
    chk("gap_first_valid", 32'(vcyc[0]), 32'd1);
    chk("gap_second_valid", 32'(vcyc[1]), 32'd6);
    chk("gap_done_cycle", 32'(cyc), 32'd8);
    chk("gap_op_cnt", 32'(op1), 32'd2);
`endif

    // NUM_OPS=3: operand sequence (corner ops first when enabled)
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    cyc = 1;
    nvalid = 0;
    while (!done2 && cyc < 40) begin
      if (bus2.valid && nvalid < 3) begin
        ga[nvalid] = bus2.a;
        gb[nvalid] = bus2.b;
        nvalid++;
      end
      tick();
      cyc++;
    end
    $display("three-op run: done at %0d, err_cnt=%0d", cyc, err2);
    chk("n3_valid_count", 32'(nvalid), 32'd3);
    for (int i = 0; i < 3; i++) begin
      $display("three-op run: op %0d a=%0h b=%0h", i, ga[i], gb[i]);
      chk("n3_a", 32'(ga[i]), 32'(ea[i]));
      chk("n3_b", 32'(gb[i]), 32'(eb[i]));
    end
    chk("n3_done_cycle", 32'(cyc), 32'd7);
    chk("n3_op_cnt", 32'(op2), 32'd3);
    chk("n3_err_cnt", 32'(err2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
